fs_rx_byte_fifo: RTL and testbench

//   Elastic byte buffer between the rx_fastserial deserialiser and the Avalon-ST
//   in_bytes_stream sink. rx_fastserial emits 1-cycle strobes with no backpressure.

---
 rtl/fs_rx_byte_fifo.sv | 145 ++++++++++++++
 tb/tb_fs_rx_byte_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_rx_byte_fifo.sv
// fs_rx_byte_fifo: elastic byte buffer between the fast-serial deserialiser and
// an Avalon-ST ready/valid sink, with sticky overflow and saturating drop count.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_data, i_valid          write side (strobe, no backpressure)
//   o_data, o_valid, i_ready Avalon-ST source
//   o_level                  bytes held, 0..CAP
//   o_overflow, o_drop_count sticky drop flag and saturating count
//   i_clr_overflow           clears flag, count and peak level
//   o_hwm                    peak level since clear (macro FSRX_FIFO_HWM_EN,
//                            otherwise tied to 0)
module fs_rx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8,
    parameter int DROP_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_valid,
    output logic [DATA_W-1:0]     o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    input  logic                  i_clr_overflow,
    output logic [DROP_W-1:0]     o_drop_count,
    output logic [DEPTH_LOG2:0]   o_hwm
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam int CAP = 1 << DEPTH_LOG2;
    localparam logic [LW-1:0] CAP_L = LW'(CAP);

    typedef enum logic [1:0] {
        EMPTY,
        NONEMPTY,
        FULL
    } occ_e;

    logic [DATA_W-1:0]     mem_q [CAP];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    occ_e                  occ;
    logic                  pop, push, drop;

    // Occupancy state is a pure function of the level register.
    always_comb begin
        occ = NONEMPTY;
        if (level_q == '0)
            occ = EMPTY;
        else if (level_q == CAP_L)
            occ = FULL;
    end

    assign o_valid = (occ != EMPTY);
    assign pop     = o_valid && i_ready;
    // When full, the freed output slot takes the byte in the same cycle.
    assign push    = i_valid && ((occ != FULL) || pop);
    assign drop    = i_valid && !push;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push)
            wptr_d = wptr_q + 1'b1;
        if (pop)
            rptr_d = rptr_q + 1'b1;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;
    end

    // A drop in the clear cycle is counted after the clear.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (i_clr_overflow) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (i_clr_overflow)
                drop_d = DROP_W'(1);
            else if (drop_q != '1)
                drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wptr_q] <= i_data;
    end

    // Head slot is not overwritten while valid, so o_data holds under stall.
    assign o_data       = o_valid ? mem_q[rptr_q] : '0;
    assign o_level      = level_q;
    assign o_overflow   = ovf_q;
    assign o_drop_count = drop_q;

`ifdef FSRX_FIFO_HWM_EN
    logic [LW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (i_clr_overflow || (level_d > hwm_q))
            hwm_d = level_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            hwm_q <= '0;
        else
            hwm_q <= hwm_d;
    end

    assign o_hwm = hwm_q;
`else
    assign o_hwm = '0;
`endif

endmodule

// File: tb/tb_fs_rx_byte_fifo.sv
// tb_fs_rx_byte_fifo: table vectors plus a queue scoreboard for the byte FIFO,
// with a narrow second instance for drop-counter saturation.
module tb_fs_rx_byte_fifo;

    localparam int CAP = 16;
`ifdef FSRX_FIFO_HWM_EN
    localparam bit HWM = 1'b1;
`else
    localparam bit HWM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid;
    logic [4:0]  o_level;
    logic        o_overflow;
    logic [15:0] o_drop_count;
    logic [4:0]  o_hwm;

    logic [7:0]  s_d = '0;
    logic        s_v = 1'b0;
    logic        s_r = 1'b0;
    logic        s_clr = 1'b0;
    logic [7:0]  s_od;
    logic        s_ov;
    logic [1:0]  s_lvl;
    logic        s_ovf;
    logic [1:0]  s_drop;
    logic [1:0]  s_hwm;

    always #5 clk = ~clk;

    fs_rx_byte_fifo dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_data(i_data), .i_valid(i_valid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_level(o_level), .o_overflow(o_overflow),
        .i_clr_overflow(clr), .o_drop_count(o_drop_count),
        .o_hwm(o_hwm)
    );

    fs_rx_byte_fifo #(.DEPTH_LOG2(1), .DATA_W(8), .DROP_W(2)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_data(s_d), .i_valid(s_v),
        .o_data(s_od), .o_valid(s_ov), .i_ready(s_r),
        .o_level(s_lvl), .o_overflow(s_ovf),
        .i_clr_overflow(s_clr), .o_drop_count(s_drop),
        .o_hwm(s_hwm)
    );

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    int         m_drop = 0;
    int         m_hwm = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       c;
        logic       ev;
        logic [7:0] ed;
        logic [4:0] el;
    } vec_t;

    vec_t t1[3];
    logic [1:0] sat_exp[7];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_hwm  = 0;
    endtask

    // Apply inputs mid-cycle, compare against the scoreboard, then clock.
    task automatic step(logic v, logic [7:0] d, logic r, logic c);
        bit pop, push, drp;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        clr     = c;
        #1;
        chk("valid", o_valid, mq.size() != 0);
        chk("level", o_level, mq.size());
        if (mq.size() != 0)
            chk("data", o_data, mq[0]);
        chk("ovf", o_overflow, m_ovf);
        chk("drops", o_drop_count, m_drop);
        chk("hwm", o_hwm, HWM ? m_hwm : 0);
        pop  = (mq.size() != 0) && r;
        push = v && ((mq.size() < CAP) || pop);
        drp  = v && !push;
        if (pop)
            void'(mq.pop_front());
        if (push)
            mq.push_back(d);
        if (c) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (drp) begin
            m_ovf = 1'b1;
            if (m_drop < 65535)
                m_drop++;
        end
        if (c || mq.size() > m_hwm)
            m_hwm = mq.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        t1[0] = '{v: 1, d: 8'hA5, r: 1, c: 0, ev: 1, ed: 8'hA5, el: 1};
        t1[1] = '{v: 0, d: 8'h00, r: 1, c: 0, ev: 0, ed: 8'h00, el: 0};
        t1[2] = '{v: 0, d: 8'h00, r: 1, c: 0, ev: 0, ed: 8'h00, el: 0};
        sat_exp = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_drops", o_drop_count, 0);
        chk("rst_hwm", o_hwm, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte: one-cycle latency, one-cycle valid.
        for (int i = 0; i < 3; i++) begin
            step(t1[i].v, t1[i].d, t1[i].r, t1[i].c);
            chk("t1_valid", o_valid, t1[i].ev);
            chk("t1_level", o_level, t1[i].el);
            if (t1[i].ev)
                chk("t1_data", o_data, t1[i].ed);
        end

        // Fill under stall.
        for (int i = 0; i < CAP; i++)
            step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_level", o_level, 16);
        chk("full_head", o_data, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_hold", o_data, 8'h00);

        // Drops when full.
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
        chk("ovf_set", o_overflow, 1);
        chk("ovf_cnt", o_drop_count, 3);
        chk("ovf_level", o_level, 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", o_overflow, 0);
        chk("clr_cnt", o_drop_count, 0);

        // Drop in the clear cycle wins.
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("clrdrop_ovf", o_overflow, 1);
        chk("clrdrop_cnt", o_drop_count, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Push and pop together while full.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("pp_level", o_level, 16);
        chk("pp_drops", o_drop_count, 0);
        chk("pp_head", o_data, 8'h01);

        // Drain: 01..0F then 55, checked by the scoreboard.
        for (int i = 0; i < CAP; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained", o_level, 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        chk("pre_rst_level", o_level, 5);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("arst_valid", o_valid, 0);
        chk("arst_level", o_level, 0);
        i_valid = 1'b1;
        i_data  = 8'hCC;
        @(posedge clk);
        #1;
        chk("rst_ignore", o_level, 0);
        i_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("post_rst_data", o_data, 8'h3C);
        chk("post_rst_valid", o_valid, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Peak level tracking.
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        chk("hwm3_level", o_level, 3);
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("hwm_peak", o_hwm, HWM ? 7 : 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("hwm_clr", o_hwm, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Saturation on the narrow instance: CAP=2, 2-bit drop counter.
        s_r = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_v = 1'b1;
            s_d = 8'h10 + 8'(i);
            @(posedge clk);
            #1;
            chk("sat_cnt", s_drop, sat_exp[i]);
        end
        s_v = 1'b0;
        chk("sat_ovf", s_ovf, 1);
        chk("sat_level", s_lvl, 2);
        chk("sat_head", s_od, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
